// File: rtl/tri_pixel_frame.sv
// ---------------------------------------------------------------------------
// tri_pixel_frame
//   Downstream stage of the right-angled triangle renderer. Captures the
//   renderer pixel stream (po/xo/yo, framed by busy_in) into a 2^CW x 2^CW
//   on-chip bitmap while counting unique pixels. When a triangle completes,
//   the bitmap is drained row by row over a valid/ready handshake.
//
//   Optional feature macro: FB_ACCUM_EN
//     defined   : bitmap and pix_cnt accumulate across triangles until clr
//     undefined : bitmap and pix_cnt are cleared at every triangle start
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   busy_in     renderer busy, high for the duration of one triangle
//   po          pixel strobe; xo/yo valid when high
//   xo, yo      pixel coordinates
//   clr         clear bitmap and counter (honoured only in IDLE)
//   row_ready   downstream accepts the presented row
//   row_valid   row_idx/row_data valid
//   row_idx     row number being presented
//   row_data    bitmap row; bit i = pixel (x=i, y=row_idx)
//   pix_cnt     unique pixels currently set in the bitmap
//   frame_done  one-cycle pulse after the last row is accepted
//   overrun     sticky: triangle started while draining
// ---------------------------------------------------------------------------
module tri_pixel_frame #(
    parameter int unsigned CW    = 3,
    parameter int unsigned CNT_W = 2 * CW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  busy_in,
    input  logic                  po,
    input  logic [CW-1:0]         xo,
    input  logic [CW-1:0]         yo,
    input  logic                  clr,
    input  logic                  row_ready,
    output logic                  row_valid,
    output logic [CW-1:0]         row_idx,
    output logic [(1<<CW)-1:0]    row_data,
    output logic [CNT_W-1:0]      pix_cnt,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int unsigned GW       = 1 << CW;
    localparam int unsigned LAST_ROW = GW - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GW * GW);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t        state;
    logic          busy_q;
    logic [GW-1:0] bitmap [GW];

    logic          rise_c;
    logic          fall_c;
    logic          capture_px_c;
    logic          px_new_c;
    logic          clear_c;
    logic [GW-1:0] px_mask_c;
    logic [GW-1:0] first_row_c;

    // Edge detect, pixel decode and clear qualification
    always_comb begin
        rise_c       = busy_in & ~busy_q;
        fall_c       = ~busy_in & busy_q;
        capture_px_c = (state == S_CAPTURE) && po;
        px_mask_c    = GW'(1) << xo;
        px_new_c     = (bitmap[yo] & px_mask_c) == '0;
`ifdef FB_ACCUM_EN
        clear_c      = (state == S_IDLE) && clr;
`else
        clear_c      = (state == S_IDLE) && (clr || rise_c);
`endif
        // Row 0 as it will look after this edge, so a pixel landing in the
        // fall cycle is already visible in the first drained row.
        first_row_c  = bitmap[0];
        if (capture_px_c && (yo == '0)) begin
            first_row_c = bitmap[0] | px_mask_c;
        end
    end

    // Bitmap storage and unique-pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GW; i++) begin
                bitmap[i] <= '0;
            end
            pix_cnt <= '0;
        end else if (clear_c) begin
            for (int i = 0; i < GW; i++) begin
                bitmap[i] <= '0;
            end
            pix_cnt <= '0;
        end else if (capture_px_c) begin
            bitmap[yo] <= bitmap[yo] | px_mask_c;
            if (px_new_c && (pix_cnt != CNT_MAX)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    // Control FSM with registered drain outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            row_valid  <= 1'b0;
            row_idx    <= '0;
            row_data   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy_q     <= busy_in;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise_c) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (fall_c) begin
                        state     <= S_DRAIN;
                        row_idx   <= '0;
                        row_valid <= 1'b1;
                        row_data  <= first_row_c;
                    end
                end
                S_DRAIN: begin
                    // A triangle arriving mid-drain is dropped; drain proceeds
                    if (rise_c) begin
                        overrun <= 1'b1;
                    end
                    if (row_ready) begin
                        if (row_idx == CW'(LAST_ROW)) begin
                            state      <= S_IDLE;
                            row_valid  <= 1'b0;
                            row_idx    <= '0;
                            row_data   <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row_idx  <= row_idx + CW'(1);
                            row_data <= bitmap[row_idx + CW'(1)];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_pixel_frame.sv
// ---------------------------------------------------------------------------
// tb_tri_pixel_frame
//   Directed self-checking bench for tri_pixel_frame (CW=3, 8x8 grid).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point.
// ---------------------------------------------------------------------------
module tb_tri_pixel_frame;

    localparam int unsigned CW    = 3;
    localparam int unsigned CNT_W = 2 * CW + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy_in;
    logic             po;
    logic [CW-1:0]    xo;
    logic [CW-1:0]    yo;
    logic             clr;
    logic             row_ready;
    logic             row_valid;
    logic [CW-1:0]    row_idx;
    logic [7:0]       row_data;
    logic [CNT_W-1:0] pix_cnt;
    logic             frame_done;
    logic             overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_rows [8];

    tri_pixel_frame #(.CW(CW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .busy_in    (busy_in),
        .po         (po),
        .xo         (xo),
        .yo         (yo),
        .clr        (clr),
        .row_ready  (row_ready),
        .row_valid  (row_valid),
        .row_idx    (row_idx),
        .row_data   (row_data),
        .pix_cnt    (pix_cnt),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input int x, input int y);
        po = 1'b1;
        xo = CW'(x);
        yo = CW'(y);
        step();
        po = 1'b0;
    endtask

    task automatic start_tri();
        busy_in = 1'b1;
        step();
    endtask

    task automatic end_tri();
        busy_in = 1'b0;
        step();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) exp_rows[i] = 8'h00;
    endtask

    // Drain all 8 rows; optionally stall 4 cycles at stall_row and raise
    // busy_in while presenting rise_row.
    task automatic drain(input int stall_row, input int rise_row);
        row_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if (r == stall_row) begin
                row_ready = 1'b0;
                repeat (4) begin
                    step();
                    check("stall_valid", 32'(row_valid), 32'd1);
                    check("stall_idx", 32'(row_idx), 32'(r));
                    check("stall_data", 32'(row_data), 32'(exp_rows[r]));
                end
                row_ready = 1'b1;
            end
            check("row_valid", 32'(row_valid), 32'd1);
            check("row_idx", 32'(row_idx), 32'(r));
            check("row_data", 32'(row_data), 32'(exp_rows[r]));
            check("no_early_done", 32'(frame_done), 32'd0);
            if (r == rise_row) busy_in = 1'b1;
            step();
            if (r == rise_row) check("overrun_set", 32'(overrun), 32'd1);
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("valid_after_drain", 32'(row_valid), 32'd0);
        check("idx_wrap", 32'(row_idx), 32'd0);
        row_ready = 1'b0;
        step();
        check("frame_done_clear", 32'(frame_done), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        busy_in   = 1'b0;
        po        = 1'b0;
        xo        = '0;
        yo        = '0;
        clr       = 1'b0;
        row_ready = 1'b0;

        // Reset values
        step();
        step();
        check("rst_valid", 32'(row_valid), 32'd0);
        check("rst_idx", 32'(row_idx), 32'd0);
        check("rst_data", 32'(row_data), 32'd0);
        check("rst_cnt", 32'(pix_cnt), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        step();

        // Triangle (0,0),(3,0),(0,3): 10 pixels
        start_tri();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4 - y; x++)
                send_px(x, y);
        check("tri_cnt", 32'(pix_cnt), 32'd10);
        check("tri_no_valid", 32'(row_valid), 32'd0);
        end_tri();
        clear_exp();
        exp_rows[0] = 8'h0F;
        exp_rows[1] = 8'h07;
        exp_rows[2] = 8'h03;
        exp_rows[3] = 8'h01;
        drain(-1, -1);
        check("tri_cnt_after", 32'(pix_cnt), 32'd10);

        // Duplicate pixel, clr ignored in CAPTURE, stall at row 2, rise at row 3
        start_tri();
        check("new_tri_cleared", 32'(pix_cnt), 32'd0);
        send_px(2, 5);
        send_px(2, 5);
        send_px(2, 5);
        check("dup_cnt", 32'(pix_cnt), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ignored_capture", 32'(pix_cnt), 32'd1);
        end_tri();
        clear_exp();
        exp_rows[5] = 8'h04;
        drain(2, 3);
        check("overrun_cnt_kept", 32'(pix_cnt), 32'd1);
        check("overrun_sticky", 32'(overrun), 32'd1);
        busy_in = 1'b0;
        step();
        check("idle_no_drain", 32'(row_valid), 32'd0);
        send_px(7, 7);
        check("po_idle_ignored", 32'(pix_cnt), 32'd1);

        // Back-to-back single-pixel triangles
        start_tri();
        send_px(1, 1);
        end_tri();
        check("tri_a_cnt", 32'(pix_cnt), 32'd1);
        clear_exp();
        exp_rows[1] = 8'h02;
        drain(-1, -1);
        start_tri();
        send_px(6, 6);
        end_tri();
        clear_exp();
        exp_rows[6] = 8'h40;
`ifdef FB_ACCUM_EN
        exp_rows[1] = 8'h02;
        check("tri_b_cnt", 32'(pix_cnt), 32'd2);
`else
        check("tri_b_cnt", 32'(pix_cnt), 32'd1);
`endif
        drain(-1, -1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_idle", 32'(pix_cnt), 32'd0);
        check("overrun_still", 32'(overrun), 32'd1);

        // Reset mid-CAPTURE after 5 pixels
        start_tri();
        for (int i = 0; i < 5; i++) send_px(i, 7);
        check("pre_rst_cnt", 32'(pix_cnt), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_cnt", 32'(pix_cnt), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        check("async_rst_valid", 32'(row_valid), 32'd0);
        busy_in = 1'b0;
        step();
        reset = 1'b1;
        po = 1'b1;
        xo = 3'd3;
        yo = 3'd3;
        step();
        step();
        po = 1'b0;
        check("po_after_rst_ignored", 32'(pix_cnt), 32'd0);
        start_tri();
        send_px(3, 3);
        end_tri();
        check("post_rst_cnt", 32'(pix_cnt), 32'd1);
        clear_exp();
        exp_rows[3] = 8'h08;
        drain(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
